// File: rtl/demux5_reg_if.sv
// rtl/demux5_reg_if.sv - write/consume bus and slot outputs of the registered 1-to-5 demux
interface demux5_reg_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
);
   logic                  wr_en;
   logic [2:0]            selector;
   logic [DATA_WIDTH-1:0] data_in;
   logic [4:0]            consume;
   logic [DATA_WIDTH-1:0] data_0;
   logic [DATA_WIDTH-1:0] data_1;
   logic [DATA_WIDTH-1:0] data_2;
   logic [DATA_WIDTH-1:0] data_3;
   logic [DATA_WIDTH-1:0] data_4;
   logic [4:0]            valid;
   logic                  sel_err;
   logic                  overwrite;
   logic [CNT_WIDTH-1:0]  wr_count;

   modport master (
      output wr_en, selector, data_in, consume,
      input  data_0, data_1, data_2, data_3, data_4,
      input  valid, sel_err, overwrite, wr_count
   );

   modport slave (
      input  wr_en, selector, data_in, consume,
      output data_0, data_1, data_2, data_3, data_4,
      output valid, sel_err, overwrite, wr_count
   );
endinterface

// File: rtl/demux5_reg.sv
// rtl/demux5_reg.sv - registered 1-to-5 result demux with per-slot valid, error/overwrite flags and write counter
module demux5_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input logic         clk,
   input logic         reset,
   demux5_reg_if.slave bus
);
   logic [DATA_WIDTH-1:0] slot_q [5];
   logic [4:0]            valid_q;
   logic [4:0]            valid_d;
   logic [4:0]            hit;
   logic                  accept;
   logic                  illegal;
   logic                  ow_d;
   logic                  sel_err_q;
   logic                  overwrite_q;
   logic [CNT_WIDTH-1:0]  count_q;

   // One-hot decode keeps illegal codes 5..7 from ever touching a slot.
   always_comb begin
      hit = '0;
      for (int k = 0; k < 5; k++) begin
         hit[k] = bus.wr_en && (bus.selector == 3'(k));
      end
      accept  = |hit;
      illegal = bus.wr_en && !accept;
      // A same-cycle consume of the target slot means the old data was taken.
      ow_d    = |(hit & valid_q & ~bus.consume);
      valid_d = (valid_q & ~bus.consume) | hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 5; k++) begin
            slot_q[k] <= '0;
         end
         valid_q     <= '0;
         sel_err_q   <= 1'b0;
         overwrite_q <= 1'b0;
         count_q     <= '0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (hit[k]) begin
               slot_q[k] <= bus.data_in;
            end
         end
         valid_q     <= valid_d;
         sel_err_q   <= illegal;
         overwrite_q <= ow_d;
         if (accept) begin
            count_q <= count_q + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.data_0    = slot_q[0];
   assign bus.data_1    = slot_q[1];
   assign bus.data_2    = slot_q[2];
   assign bus.data_3    = slot_q[3];
   assign bus.data_4    = slot_q[4];
   assign bus.valid     = valid_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.overwrite = overwrite_q;
   assign bus.wr_count  = count_q;
endmodule

// File: tb/tb_demux5_reg.sv
// tb/tb_demux5_reg.sv - directed and randomized bench for demux5_reg against a slot-level reference model
module tb_demux5_reg;
   logic clk = 1'b0;
   logic reset;

   demux5_reg_if #(.DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

   demux5_reg #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_data [5];
   logic [4:0]  m_valid;
   int          m_count;
   logic        m_sel_err;
   logic        m_overwrite;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".data_0"}, bus.data_0, m_data[0]);
      check({tag, ".data_1"}, bus.data_1, m_data[1]);
      check({tag, ".data_2"}, bus.data_2, m_data[2]);
      check({tag, ".data_3"}, bus.data_3, m_data[3]);
      check({tag, ".data_4"}, bus.data_4, m_data[4]);
      check({tag, ".valid"}, bus.valid, m_valid);
      check({tag, ".sel_err"}, bus.sel_err, m_sel_err);
      check({tag, ".overwrite"}, bus.overwrite, m_overwrite);
      check({tag, ".wr_count"}, bus.wr_count, 64'(m_count));
   endtask

   // Reference behaviour: apply the sampled inputs to the slot model, then compare after the edge.
   task automatic step(input string tag, input logic rst, input logic we, input int sel,
                       input logic [31:0] din, input logic [4:0] cons);
      reset        = rst;
      bus.wr_en    = we;
      bus.selector = 3'(sel);
      bus.data_in  = din;
      bus.consume  = cons;
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 5; k++) m_data[k] = 0;
         m_valid     = 0;
         m_count     = 0;
         m_sel_err   = 0;
         m_overwrite = 0;
      end else begin
         m_sel_err   = we && sel >= 5;
         m_overwrite = we && sel < 5 && m_valid[sel] && !cons[sel];
         for (int k = 0; k < 5; k++) if (cons[k]) m_valid[k] = 1'b0;
         if (we && sel < 5) begin
            m_data[sel]  = din;
            m_valid[sel] = 1'b1;
            m_count      = (m_count + 1) % 256;
         end
      end
      #1;
      compare_all(tag);
   endtask

   initial begin
      int start_count;
      for (int k = 0; k < 5; k++) m_data[k] = 'x;
      m_valid = 'x; m_count = 0; m_sel_err = 0; m_overwrite = 0;

      step("reset0", 1, 0, 0, 0, 0);
      step("reset1", 1, 0, 0, 0, 0);
      step("idle", 0, 0, 3, 32'hFFFF_FFFF, 0);
      check("idle_count_zero", bus.wr_count, 0);

      for (int k = 0; k < 5; k++) step("fill", 0, 1, k, 32'hA0 + k, 0);
      check("fill_valid", bus.valid, 5'b11111);
      check("fill_count", bus.wr_count, 5);
      check("fill_data_3", bus.data_3, 32'hA3);

      step("ow_first", 0, 1, 2, 32'h1234, 5'b00000);
      check("ow_first_flag", bus.overwrite, 1);
      step("ow_second", 0, 1, 2, 32'h5678, 5'b00100);
      check("ow_second_flag", bus.overwrite, 0);
      check("ow_second_data", bus.data_2, 32'h5678);
      check("ow_second_valid2", bus.valid[2], 1);

      step("consume_multi", 0, 0, 0, 0, 5'b10011);
      check("consume_multi_valid", bus.valid, 5'b01100);
      step("consume_invalid", 0, 1, 3, 32'h77, 5'b00001);

      step("illegal", 0, 1, 6, 32'hDEAD, 0);
      check("illegal_flag", bus.sel_err, 1);
      check("illegal_data_0", bus.data_0, 32'hA0);
      step("illegal_after", 0, 0, 6, 32'hDEAD, 0);
      check("illegal_pulse_end", bus.sel_err, 0);
      step("illegal_5", 0, 1, 5, 32'hBEEF, 0);
      step("illegal_7", 0, 1, 7, 32'hBEEF, 0);

      start_count = m_count;
      for (int i = 0; i < 256; i++) step("wrap", 0, 1, i % 5, $urandom, 5'b11111);
      check("wrap_count", bus.wr_count, 64'(start_count));
      check("wrap_no_ow", bus.overwrite, 0);

      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
      end

      step("mid_rst_clr", 0, 0, 0, 0, 5'b11111);
      step("mid_w0", 0, 1, 0, 32'h11, 0);
      step("mid_w2", 0, 1, 2, 32'h22, 0);
      step("mid_w4", 0, 1, 4, 32'h44, 0);
      check("mid_valid_pre", bus.valid, 5'b10101);
      step("mid_reset", 1, 1, 1, 32'h99, 0);
      check("mid_valid", bus.valid, 0);
      check("mid_count", bus.wr_count, 0);
      check("mid_data_1", bus.data_1, 0);
      step("post_reset_write", 0, 1, 1, 32'h55, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
